dvp_pixel_receiver: RTL and testbench

- Parametrised successor of the camera DVP front end.
- Samples an N-bit parallel video bus on pclk and assembles BYTES_PER_PIXEL consecutive HREF-qualified words into one pixel.
- Emits pixels as an AXI4-Stream video beat (TUSER=SOF, TLAST=EOL) with real TREADY backpressure, overflow/partial-pixel error detection and measured frame geometry.
- Sits between the sensor pins and the VDMA/video pipeline, in the pclk domain.

---
 rtl/dvp_pkg.sv | 21 ++
 rtl/dvp_pixel_receiver_if.sv | 15 +
 rtl/dvp_word_packer.sv | 57 +++++
 rtl/dvp_pixel_receiver.sv | 193 +++++++++++++++++++
 tb/tb_dvp_pixel_receiver.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP pixel receiver: polarity constants,
// beat marker struct, default counter width and a polarity helper.
package dvp_pkg;

    localparam bit ACTIVE_LOW  = 1'b0;
    localparam bit ACTIVE_HIGH = 1'b1;

    localparam int unsigned CNT_WIDTH_DEFAULT = 16;

    // Line/frame markers travelling with a pixel beat (TLAST, TUSER).
    typedef struct packed {
        logic last;
        logic user;
    } beat_tag_t;

    // Returns 1 when the pin is at its asserted level.
    function automatic logic normalize(input logic level, input bit active_high);
        return active_high ? level : ~level;
    endfunction

endpackage

// File: rtl/dvp_pixel_receiver_if.sv
// AXI4-Stream video beat bundle between the receiver and the downstream sink.
interface dvp_pixel_receiver_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/dvp_word_packer.sv
// Collects BYTES_PER_PIXEL sensor words into one pixel. The completed pixel
// (including the word arriving this cycle) is presented combinationally
// together with a one-cycle complete strobe.
module dvp_word_packer #(
    parameter int unsigned DIN_WIDTH       = 8,
    parameter int unsigned BYTES_PER_PIXEL = 2,
    parameter bit          FIRST_WORD_MSB  = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DIN_WIDTH-1:0]                 word,
    input  logic                                 word_valid,
    input  logic                                 line_end,
    input  logic                                 abort,
    output logic [DIN_WIDTH*BYTES_PER_PIXEL-1:0] pixel,
    output logic                                 complete,
    output logic                                 partial
);

    localparam int unsigned DATA_W = DIN_WIDTH * BYTES_PER_PIXEL;
    localparam int unsigned CW     = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_PER_PIXEL - 1);

    logic [CW-1:0]     word_cnt;
    logic [CW-1:0]     slot;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_next;

    // Insert the current word into the slice chosen by word order.
    always_comb begin
        slot     = FIRST_WORD_MSB ? (LAST_IDX - word_cnt) : word_cnt;
        asm_next = asm_q;
        for (int unsigned i = 0; i < BYTES_PER_PIXEL; i++) begin
            if (slot == CW'(i)) begin
                asm_next[i*DIN_WIDTH +: DIN_WIDTH] = word;
            end
        end
    end

    assign pixel    = asm_next;
    assign complete = word_valid & ~abort & (word_cnt == LAST_IDX);
    assign partial  = line_end & (word_cnt != '0);

    // Word counter and assembly register; aborts and line ends drop partial words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            asm_q    <= '0;
        end else if (abort || line_end) begin
            word_cnt <= '0;
        end else if (word_valid) begin
            asm_q    <= asm_next;
            word_cnt <= complete ? '0 : word_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dvp_pixel_receiver.sv
// Camera DVP front end: samples the parallel sensor bus, packs words into
// pixels and emits them as AXI4-Stream video beats (TUSER=SOF, TLAST=EOL)
// with backpressure, sticky error flags and measured frame geometry.
module dvp_pixel_receiver
    import dvp_pkg::*;
#(
    parameter int unsigned DIN_WIDTH         = 8,
    parameter int unsigned BYTES_PER_PIXEL   = 2,
    parameter bit          FIRST_WORD_MSB    = 1'b1,
    parameter bit          VSYNC_ACTIVE_HIGH = ACTIVE_LOW,
    parameter bit          HREF_ACTIVE_HIGH  = ACTIVE_HIGH,
    parameter int unsigned CNT_WIDTH         = CNT_WIDTH_DEFAULT
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  href_in,
    input  logic                  vsync_in,
    dvp_pixel_receiver_if.master  axis,
    output logic [CNT_WIDTH-1:0]  line_width,
    output logic [CNT_WIDTH-1:0]  frame_height,
    output logic                  overflow,
    output logic                  partial_err
);

    localparam int unsigned DATA_W = DIN_WIDTH * BYTES_PER_PIXEL;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        beat_tag_t         tag;
    } beat_t;

    logic [DIN_WIDTH-1:0] din_q;
    logic                 href_q;
    logic                 vsync_q;
    logic                 href_prev;
    logic                 vsync_prev;

    logic                 href_fall;
    logic                 vsync_rise;
    logic                 line_end;

    logic [DATA_W-1:0]    pixel;
    logic                 complete;
    logic                 partial;

    logic [DATA_W-1:0]    pend_data;
    logic                 pend_valid;
    logic                 sof_armed;

    logic                 push;
    beat_t                push_beat;
    beat_t                out_beat;
    logic                 out_valid;
    logic                 accept;

    logic [CNT_WIDTH-1:0] pix_cnt;
    logic [CNT_WIDTH-1:0] line_cnt;

    // Input stage: register pins after polarity normalisation, keep history for edges.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            din_q      <= '0;
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            href_prev  <= 1'b0;
            vsync_prev <= 1'b0;
        end else begin
            din_q      <= din;
            href_q     <= normalize(href_in, HREF_ACTIVE_HIGH);
            vsync_q    <= normalize(vsync_in, VSYNC_ACTIVE_HIGH);
            href_prev  <= href_q;
            vsync_prev <= vsync_q;
        end
    end

    assign href_fall  = href_prev & ~href_q;
    assign vsync_rise = vsync_q & ~vsync_prev;
    // A line that ends under vsync is an aborted line, not a real line end.
    assign line_end   = href_fall & ~vsync_q;

    dvp_word_packer #(
        .DIN_WIDTH      (DIN_WIDTH),
        .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
        .FIRST_WORD_MSB (FIRST_WORD_MSB)
    ) u_packer (
        .clk       (pclk),
        .rst       (rst),
        .word      (din_q),
        .word_valid(href_q),
        .line_end  (line_end),
        .abort     (vsync_q),
        .pixel     (pixel),
        .complete  (complete),
        .partial   (partial)
    );

    // Forward the pending pixel once its end-of-line status is known.
    always_comb begin
        push               = 1'b0;
        push_beat.data     = pend_data;
        push_beat.tag.last = line_end;
        push_beat.tag.user = sof_armed;
        if (!vsync_q && pend_valid && (complete || line_end)) begin
            push = 1'b1;
        end
    end

    // Pending pixel holder and start-of-frame arming.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_valid <= 1'b0;
            sof_armed  <= 1'b0;
        end else begin
            if (vsync_q) begin
                pend_valid <= 1'b0;
            end else if (complete) begin
                pend_data  <= pixel;
                pend_valid <= 1'b1;
            end else if (line_end) begin
                pend_valid <= 1'b0;
            end

            if (vsync_q) begin
                sof_armed <= 1'b1;
            end else if (push) begin
                sof_armed <= 1'b0;
            end
        end
    end

    assign accept = out_valid & axis.tready;

    // Output beat register; a push into a stalled beat is dropped but its markers survive.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            out_beat    <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            partial_err <= 1'b0;
        end else begin
            if (push) begin
                if (!out_valid || accept) begin
                    out_beat  <= push_beat;
                    out_valid <= 1'b1;
                end else begin
                    overflow          <= 1'b1;
                    out_beat.tag.last <= out_beat.tag.last | push_beat.tag.last;
                    out_beat.tag.user <= out_beat.tag.user | push_beat.tag.user;
                end
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            if (partial) begin
                partial_err <= 1'b1;
            end
        end
    end

    assign axis.tdata  = out_beat.data;
    assign axis.tlast  = out_beat.tag.last;
    assign axis.tuser  = out_beat.tag.user;
    assign axis.tvalid = out_valid;

    // Geometry: saturating pixels-per-line and lines-per-frame counters.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            line_width   <= '0;
            frame_height <= '0;
        end else begin
            if (vsync_q) begin
                pix_cnt <= '0;
            end else if (line_end) begin
                line_width <= pix_cnt;
                pix_cnt    <= '0;
            end else if (complete && pix_cnt != '1) begin
                pix_cnt <= pix_cnt + CNT_WIDTH'(1);
            end

            if (vsync_rise) begin
                frame_height <= line_cnt;
                line_cnt     <= '0;
            end else if (line_end && line_cnt != '1) begin
                line_cnt <= line_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dvp_pixel_receiver.sv
// Scoreboard bench for dvp_pixel_receiver: two instances (MSB-first and
// LSB-first word order) share one stimulus; expected beats come from a
// per-line model and are checked by independent monitors.
module tb_dvp_pixel_receiver;

    localparam int unsigned DW  = 8;
    localparam int unsigned BPP = 2;
    localparam int unsigned TW  = DW * BPP;

    typedef struct {
        logic [TW-1:0] dm;
        logic [TW-1:0] dl;
        logic          last;
        logic          user;
    } exp_t;

    logic          pclk = 1'b0;
    logic          rst  = 1'b1;
    logic [DW-1:0] din  = '0;
    logic          href_in  = 1'b0;  // active high
    logic          vsync_in = 1'b1;  // active low
    logic          tready   = 1'b1;

    logic [15:0] lw_m, fh_m, lw_l, fh_l;
    logic        ovf_m, perr_m, ovf_l, perr_l;

    dvp_pixel_receiver_if #(.DATA_WIDTH(TW)) ax_m ();
    dvp_pixel_receiver_if #(.DATA_WIDTH(TW)) ax_l ();

    assign ax_m.tready = tready;
    assign ax_l.tready = tready;

    dvp_pixel_receiver dut_m (
        .pclk(pclk), .rst(rst), .din(din), .href_in(href_in), .vsync_in(vsync_in),
        .axis(ax_m), .line_width(lw_m), .frame_height(fh_m),
        .overflow(ovf_m), .partial_err(perr_m)
    );

    dvp_pixel_receiver #(.FIRST_WORD_MSB(1'b0)) dut_l (
        .pclk(pclk), .rst(rst), .din(din), .href_in(href_in), .vsync_in(vsync_in),
        .axis(ax_l), .line_width(lw_l), .frame_height(fh_l),
        .overflow(ovf_l), .partial_err(perr_l)
    );

    always #5 pclk = ~pclk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    exp_t q_m[$];
    exp_t q_l[$];

    // Reference model state
    bit          sof          = 1'b0;
    int unsigned lines        = 0;
    int unsigned exp_width    = 0;
    int unsigned exp_height   = 0;
    bit          exp_partial  = 1'b0;
    bit          exp_overflow = 1'b0;
    logic [DW-1:0] seq_word   = 8'h01;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the MSB-first instance
    exp_t em;
    always @(negedge pclk) begin
        if (!rst && ax_m.tvalid && ax_m.tready) begin
            if (q_m.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL msb_unexpected_beat: got tdata 0x%0h, expected no beat", ax_m.tdata);
            end else begin
                em = q_m.pop_front();
                check("msb_tdata", 32'(ax_m.tdata), 32'(em.dm));
                check("msb_tlast", 32'(ax_m.tlast), 32'(em.last));
                check("msb_tuser", 32'(ax_m.tuser), 32'(em.user));
            end
        end
    end

    // Monitor for the LSB-first instance
    exp_t el;
    always @(negedge pclk) begin
        if (!rst && ax_l.tvalid && ax_l.tready) begin
            if (q_l.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL lsb_unexpected_beat: got tdata 0x%0h, expected no beat", ax_l.tdata);
            end else begin
                el = q_l.pop_front();
                check("lsb_tdata", 32'(ax_l.tdata), 32'(el.dl));
                check("lsb_tlast", 32'(ax_l.tlast), 32'(el.last));
                check("lsb_tuser", 32'(ax_l.tuser), 32'(el.user));
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic exp_t make_pixel(input logic [DW-1:0] w[$], input int unsigned p);
        exp_t e;
        e.dm = '0;
        e.dl = '0;
        e.last = 1'b0;
        e.user = 1'b0;
        for (int unsigned j = 0; j < BPP; j++) begin
            e.dm[(BPP-1-j)*DW +: DW] = w[p*BPP + j];
            e.dl[j*DW +: DW]         = w[p*BPP + j];
        end
        return e;
    endfunction

    task automatic drive_words(input logic [DW-1:0] w[$]);
        foreach (w[i]) begin
            tick();
            din     = w[i];
            href_in = 1'b1;
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_line_width_m"}, 32'(lw_m), exp_width);
        check({tag, "_line_width_l"}, 32'(lw_l), exp_width);
        check({tag, "_partial_err"}, 32'(perr_m), 32'(exp_partial));
        check({tag, "_overflow"}, 32'(ovf_m), 32'(exp_overflow));
    endtask

    // One href line; blocked=1 means tready is held low for the whole line.
    task automatic send_line(input int unsigned n_words, input bit seq, input bit blocked);
        logic [DW-1:0] w[$];
        int unsigned   npix;
        exp_t          e;
        for (int unsigned i = 0; i < n_words; i++) begin
            if (seq) begin
                w.push_back(seq_word);
                seq_word = seq_word + 8'd1;
            end else begin
                w.push_back(DW'($urandom));
            end
        end
        npix = n_words / BPP;
        for (int unsigned p = 0; p < npix; p++) begin
            e      = make_pixel(w, p);
            e.user = sof && (p == 0);
            e.last = (p == npix - 1);
            if (blocked) begin
                if (p == 0) begin
                    e.last = 1'b1;  // the line's last marker merges into the held beat
                    q_m.push_back(e);
                    q_l.push_back(e);
                end
            end else begin
                q_m.push_back(e);
                q_l.push_back(e);
            end
        end
        if (blocked && npix > 1) exp_overflow = 1'b1;
        if (npix > 0) sof = 1'b0;
        if ((n_words % BPP) != 0) exp_partial = 1'b1;
        exp_width = npix;
        lines++;

        drive_words(w);
        tick();
        href_in = 1'b0;
        din     = DW'($urandom);
        repeat (4) tick();
        check_flags("line");
    endtask

    task automatic vsync_pulse();
        tick();
        vsync_in = 1'b0;
        repeat (2) tick();
        vsync_in = 1'b1;
        repeat (4) tick();
        exp_height = lines;
        lines = 0;
        sof   = 1'b1;
        check("frame_height_m", 32'(fh_m), exp_height);
        check("frame_height_l", 32'(fh_l), exp_height);
    endtask

    // Line cut short by vsync right after n_words words (a whole number of pixels).
    task automatic abort_line(input int unsigned n_words);
        logic [DW-1:0] w[$];
        int unsigned   npix;
        exp_t          e;
        for (int unsigned i = 0; i < n_words; i++) w.push_back(DW'($urandom));
        npix = n_words / BPP;
        for (int unsigned p = 0; p + 1 < npix; p++) begin
            e      = make_pixel(w, p);
            e.user = sof && (p == 0);
            e.last = 1'b0;
            q_m.push_back(e);
            q_l.push_back(e);
        end
        drive_words(w);
        tick();
        href_in  = 1'b0;
        vsync_in = 1'b0;
        repeat (2) tick();
        vsync_in = 1'b1;
        repeat (4) tick();
        exp_height = lines;
        lines = 0;
        sof   = 1'b1;
        check("abort_frame_height", 32'(fh_m), exp_height);
        check("abort_line_width", 32'(lw_m), exp_width);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nl;
        #2;
        check("rst_tvalid", 32'(ax_m.tvalid), 32'd0);
        check("rst_line_width", 32'(lw_m), 32'd0);
        check("rst_frame_height", 32'(fh_m), 32'd0);
        check("rst_overflow", 32'(ovf_m), 32'd0);
        check("rst_partial_err", 32'(perr_m), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Sequential frame: 3 lines x 4 pixels, words 0x01..0x18
        vsync_pulse();
        for (int i = 0; i < 3; i++) send_line(8, 1'b1, 1'b0);
        vsync_pulse();

        // Random frames with whole-pixel lines
        for (int f = 0; f < 3; f++) begin
            nl = $urandom_range(1, 4);
            for (int unsigned i = 0; i < nl; i++) send_line(2 * $urandom_range(1, 6), 1'b0, 1'b0);
            vsync_pulse();
        end

        // Backpressure over a whole line, then normal streaming
        tready = 1'b0;
        send_line(8, 1'b0, 1'b1);
        tready = 1'b1;
        repeat (3) tick();
        send_line(8, 1'b0, 1'b0);
        send_line(6, 1'b0, 1'b0);

        // Line ending mid-pixel
        send_line(7, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0);
        vsync_pulse();

        // Vsync mid-line after two pixels
        send_line(6, 1'b0, 1'b0);
        abort_line(4);
        send_line(8, 1'b0, 1'b0);
        vsync_pulse();

        repeat (10) tick();
        check("queue_m_empty", 32'(q_m.size()), 32'd0);
        check("queue_l_empty", 32'(q_l.size()), 32'd0);

        // Asynchronous reset while a beat is held
        tready = 1'b0;
        send_line(8, 1'b0, 1'b1);
        check("held_tvalid", 32'(ax_m.tvalid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", 32'(ax_m.tvalid), 32'd0);
        check("async_rst_overflow", 32'(ovf_m), 32'd0);
        check("async_rst_line_width", 32'(lw_m), 32'd0);
        q_m.delete();
        q_l.delete();
        repeat (2) tick();
        rst = 1'b0;
        tready = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
